scan_select_sequencer: RTL

- Upstream driver for the 3-to-8 one-hot decoder. Generates the select bus and the enable that feed the decoder's `i` and `e` inputs.
- Steps the select through all codes at a programmable rate, or one code per manual step.
- Drops enable for a programmable dead time around each select change, so decoded outputs (e.g. display anodes) never ghost.

---
 rtl/scan_select_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/scan_select_sequencer.sv
// rtl/scan_select_sequencer.sv - select/enable sequencer driving a one-hot decoder with dead-time blanking
module scan_select_sequencer #(
    parameter int SEL_W = 3,
    parameter int PRE_W = 16,
    parameter int BLANK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             dir,
    input  logic [PRE_W-1:0] period,
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic             tick,
    output logic             wrap
);

    typedef enum logic [1:0] {
        st_stop  = 2'd0,
        st_run   = 2'd1,
        st_blank = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] SEL_MAX    = '1;
    localparam logic [2:0]       BLANK_LAST = (BLANK > 0) ? 3'(BLANK - 1) : 3'd0;

    state_t           state, state_n;
    logic [PRE_W-1:0] pcnt, pcnt_n;
    logic [2:0]       bcnt, bcnt_n;
    logic [SEL_W-1:0] sel_n;
    logic             en_n, tick_n, wrap_n;
    logic             step_q, step_rise, adv;

    assign step_rise = step & ~step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= st_stop;
            pcnt   <= '0;
            bcnt   <= '0;
            sel    <= '0;
            en     <= 1'b0;
            tick   <= 1'b0;
            wrap   <= 1'b0;
            step_q <= 1'b0;
        end else begin
            state  <= state_n;
            pcnt   <= pcnt_n;
            bcnt   <= bcnt_n;
            sel    <= sel_n;
            en     <= en_n;
            tick   <= tick_n;
            wrap   <= wrap_n;
            step_q <= step;
        end
    end

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        bcnt_n  = bcnt;
        sel_n   = sel;
        adv     = 1'b0;
        wrap_n  = 1'b0;

        case (state)
            st_stop: begin
                pcnt_n = '0;
                if (run) begin
                    state_n = st_run;
                end else if (step_rise) begin
                    adv = 1'b1;
                end
            end
            st_run: begin
                if (!run) begin
                    state_n = st_stop;
                    pcnt_n  = '0;
                end else if (pcnt == period) begin
                    adv    = 1'b1;
                    pcnt_n = '0;
                end else if (pcnt > period) begin
                    pcnt_n = '0;
                end else begin
                    pcnt_n = pcnt + 1'b1;
                end
            end
            st_blank: begin
                // Prescaler keeps running but parks at period so a due advance waits for RUN
                pcnt_n = (pcnt >= period) ? period : pcnt + 1'b1;
                if (bcnt == BLANK_LAST) begin
                    state_n = run ? st_run : st_stop;
                    if (!run) begin
                        pcnt_n = '0;
                    end
                end else begin
                    bcnt_n = bcnt + 3'd1;
                end
            end
            default: begin
                state_n = st_stop;
                pcnt_n  = '0;
            end
        endcase

        if (adv) begin
            sel_n  = dir ? sel - 1'b1 : sel + 1'b1;
            wrap_n = dir ? (sel == '0) : (sel == SEL_MAX);
            if (BLANK > 0) begin
                state_n = st_blank;
                bcnt_n  = 3'd0;
            end
        end

        tick_n = adv;
        en_n   = (state_n != st_blank);
    end

endmodule
